// File: rtl/lcompressor_env.sv
// Peak-envelope compressor: abs -> envelope -> gain reduction, 3-stage CE pipeline.
// Optional gain-reduction meter output enabled by LCOMPRESSOR_ENV_GR_METER_EN.
module lcompressor_env #(
   parameter int W_TOTAL = 16,
   parameter int W_SHIFT = 4,
   parameter int W_RATIO = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_ce,
   input  logic               i_mode,
   input  logic [W_TOTAL-1:0] i_data,
   input  logic [W_TOTAL-2:0] i_threshold,
   input  logic [W_RATIO-1:0] i_ratio_shift,
   input  logic [W_SHIFT-1:0] i_atk_shift,
   input  logic [W_SHIFT-1:0] i_rel_shift,
`ifdef LCOMPRESSOR_ENV_GR_METER_EN
   output logic [W_TOTAL-2:0] o_gain_red,
`endif
   output logic [W_TOTAL-1:0] o_data,
   output logic               o_ce
);

   localparam int M = W_TOTAL - 1;
   localparam logic [W_TOTAL-1:0] MOST_NEG = {1'b1, {M{1'b0}}};
   localparam logic [M-1:0] MAG_MAX = '1;
   localparam logic [M-1:0] MAG_ONE = {{(M-1){1'b0}}, 1'b1};

   logic         sign1;
   logic [M-1:0] abs1;
   logic         sign2;
   logic [M-1:0] abs2;
   logic [M-1:0] env;
   logic [1:0]   fill;

   logic [M-1:0] abs_in;
   logic         rise;
   logic [M-1:0] diff;
   logic [M-1:0] step;
   logic [M-1:0] env_nxt;
   logic [M-1:0] excess;
   logic [M-1:0] red;
   logic [M-1:0] mag;
   logic [W_TOTAL-1:0] pos_out;
   logic [W_TOTAL-1:0] out_nxt;

   // most-negative input has no positive twin; clamp to full scale
   always_comb begin
      abs_in = i_data[M-1:0];
      if (i_data == MOST_NEG)
         abs_in = MAG_MAX;
      else if (i_data[W_TOTAL-1])
         abs_in = ~i_data[M-1:0] + MAG_ONE;
   end

   // difference form keeps the envelope inside [min(abs,env), max(abs,env)]
   always_comb begin
      rise    = abs1 > env;
      diff    = rise ? (abs1 - env) : (env - abs1);
      step    = rise ? (diff >> i_atk_shift) : (diff >> i_rel_shift);
      env_nxt = rise ? (env + step) : (env - step);
   end

   always_comb begin
      excess  = (env > i_threshold) ? (env - i_threshold) : '0;
      red     = excess - (excess >> i_ratio_shift);
      mag     = abs2;
      if (i_mode)
         mag = (abs2 > red) ? (abs2 - red) : '0;
      pos_out = {1'b0, mag};
      out_nxt = sign2 ? (~pos_out + 1'b1) : pos_out;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sign1 <= 1'b0;
         abs1  <= '0;
      end else if (i_ce) begin
         sign1 <= i_data[W_TOTAL-1];
         abs1  <= abs_in;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sign2 <= 1'b0;
         abs2  <= '0;
         env   <= '0;
      end else if (i_ce) begin
         sign2 <= sign1;
         abs2  <= abs1;
         env   <= env_nxt;
      end
   end

   // fill[1] set once two earlier strobes have primed stages 1 and 2
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         fill   <= 2'd0;
         o_data <= '0;
         o_ce   <= 1'b0;
      end else begin
         o_ce <= 1'b0;
         if (i_ce) begin
            if (fill != 2'd3)
               fill <= fill + 2'd1;
            if (fill[1]) begin
               o_data <= out_nxt;
               o_ce   <= 1'b1;
            end
         end
      end
   end

`ifdef LCOMPRESSOR_ENV_GR_METER_EN
   logic [M-1:0] gr_decay;

   // peak hold: jump up to a larger reduction, otherwise bleed off by 1/256
   assign gr_decay = o_gain_red - (o_gain_red >> 8);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         o_gain_red <= '0;
      else if (i_ce && fill[1])
         o_gain_red <= (red > gr_decay) ? red : gr_decay;
   end
`endif

endmodule

// File: tb/tb_lcompressor_env.sv
// Scoreboard bench for lcompressor_env: behavioural model feeds an expected
// queue, a negedge monitor pops and compares on every o_ce pulse.
module tb_lcompressor_env;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        mode;
   logic [15:0] data;
   logic [14:0] thr;
   logic [2:0]  r;
   logic [3:0]  a;
   logic [3:0]  b;
   logic [15:0] odata;
   logic        oce;
`ifdef LCOMPRESSOR_ENV_GR_METER_EN
   logic [14:0] gain_red;
`endif

   lcompressor_env dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_ce          (ce),
      .i_mode        (mode),
      .i_data        (data),
      .i_threshold   (thr),
      .i_ratio_shift (r),
      .i_atk_shift   (a),
      .i_rel_shift   (b),
`ifdef LCOMPRESSOR_ENV_GR_METER_EN
      .o_gain_red    (gain_red),
`endif
      .o_data        (odata),
      .o_ce          (oce)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit sgn;
      int mag;
   } samp_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   samp_t       pend[$];
   int          env_m = 0;
   int          pulses = 0;
   logic [15:0] last_out = '0;
   bit          rec = 1'b0;
   logic [15:0] seen[$];

   function automatic void check(string nm, logic [15:0] got, logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
      end
   endfunction

   function automatic void check_int(string nm, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
      end
   endfunction

   function automatic samp_t to_samp(logic [15:0] d);
      samp_t s;
      int v = int'(d);
      s.sgn = d[15];
      if (v == 32768) s.mag = 32767;
      else if (v > 32768) s.mag = 65536 - v;
      else s.mag = v;
      return s;
   endfunction

   // model of one strobe: emit result of sample j-2, then fold sample j-1 into env
   function automatic void model_strobe(logic [15:0] d);
      int ex;
      int rd;
      int mg;
      int x;
      samp_t s;
      if (pend.size() == 2) begin
         s  = pend.pop_front();
         ex = (env_m > int'(thr)) ? env_m - int'(thr) : 0;
         rd = ex - (ex >> int'(r));
         mg = s.mag;
         if (mode) mg = (s.mag > rd) ? s.mag - rd : 0;
         exp_q.push_back(s.sgn ? 16'(-mg) : 16'(mg));
      end
      if (pend.size() == 1) begin
         x = pend[0].mag;
         if (x > env_m) env_m = env_m + ((x - env_m) >> int'(a));
         else env_m = env_m - ((env_m - x) >> int'(b));
      end
      pend.push_back(to_samp(d));
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         last_out = '0;
      end else if (oce) begin
         pulses++;
         if (rec) seen.push_back(odata);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_o_ce: got o_data %h with no expected entry at %0t", odata, $time);
         end else begin
            check("o_data", odata, exp_q.pop_front());
         end
         last_out = odata;
      end else begin
         check("hold", odata, last_out);
      end
   end

   task automatic cyc(input bit en, input logic [15:0] d);
      data = d;
      ce   = en;
      if (en) model_strobe(d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ce  = 1'b0;
      exp_q.delete();
      pend.delete();
      env_m = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [15:0] rnd_data();
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(15) == 0) v = 16'h8000;
      return v;
   endfunction

   task automatic rnd_ctrl();
      thr  = 15'($urandom);
      r    = 3'($urandom);
      a    = 4'($urandom_range(6));
      b    = 4'($urandom_range(8));
      mode = ($urandom_range(3) != 0);
   endtask

   logic [15:0] seq[30];
   logic [15:0] run_a[$];
   int p0;

   initial begin
      rst = 1'b1; ce = 1'b0; mode = 1'b1; data = '0;
      thr = '0; r = '0; a = '0; b = '0;
      @(posedge clk);
      #1;
      check("reset_o_data", odata, 16'h0000);
      check_int("reset_o_ce", int'(oce), 0);
      do_reset();

      mode = 1'b1; thr = 15'h4000; r = 3'd1; a = 4'd0; b = 4'd0;
      repeat (5) cyc(1'b1, 16'h6000);
      cyc(1'b0, '0);
      check("steady_pos", odata, 16'h5000);
      repeat (5) cyc(1'b1, 16'hA000);
      cyc(1'b0, '0);
      check("steady_neg", odata, 16'hB000);

      repeat (4) cyc(1'b1, 16'h3000);
      cyc(1'b0, '0);
      check("below_thr", odata, 16'h3000);
      thr = 15'h1000; r = 3'd0;
      repeat (4) cyc(1'b1, 16'h6000);
      cyc(1'b0, '0);
      check("ratio_1to1", odata, 16'h6000);

      thr = 15'h4000; r = 3'd1; a = 4'd0; b = 4'd2;
      repeat (4) cyc(1'b1, 16'h6000);
      cyc(1'b1, 16'h0000);
      cyc(1'b1, 16'h4000);
      cyc(1'b1, 16'h4000);
      cyc(1'b0, '0);
      check("release_zero", odata, 16'h0000);
      cyc(1'b1, 16'h4000);
      cyc(1'b0, '0);
      check("release_mem", odata, 16'h3D00);

      mode = 1'b0;
      cyc(1'b1, 16'h8000);
      cyc(1'b1, 16'h1234);
      cyc(1'b1, 16'h1234);
      cyc(1'b0, '0);
      check("bypass_sat", odata, 16'h8001);
      cyc(1'b1, 16'h1234);
      cyc(1'b0, '0);
      check("bypass_pass", odata, 16'h1234);

      rnd_ctrl();
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(7) == 0) rnd_ctrl();
         cyc(($urandom_range(3) != 0), rnd_data());
      end

      repeat (2) cyc(1'b1, rnd_data());
      do_reset();
      p0 = pulses;
      cyc(1'b1, 16'h7000);
      cyc(1'b1, 16'h7000);
      repeat (3) cyc(1'b0, '0);
      check_int("reset_no_ce", pulses - p0, 0);
      check("reset_data_zero", odata, 16'h0000);
      cyc(1'b1, 16'h7000);
      cyc(1'b0, '0);
      check_int("reset_third_ce", pulses - p0, 1);

      for (int i = 0; i < 30; i++) seq[i] = rnd_data();
      mode = 1'b1; thr = 15'h2000; r = 3'd2; a = 4'd1; b = 4'd3;
      do_reset();
      seen.delete();
      rec = 1'b1;
      for (int i = 0; i < 30; i++) cyc(1'b1, seq[i]);
      repeat (3) cyc(1'b0, '0);
      rec = 1'b0;
      run_a = seen;
      do_reset();
      seen.delete();
      rec = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cyc(1'b1, seq[i]);
         repeat (4) cyc(1'b0, '0);
      end
      rec = 1'b0;
      check_int("gap_count", seen.size(), run_a.size());
      for (int i = 0; i < run_a.size() && i < seen.size(); i++)
         check("gap_vs_b2b", seen[i], run_a[i]);

      repeat (4) cyc(1'b0, '0);
      check_int("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
